// File: rtl/ustack_pkg.sv
// Shared types and defaults for the microcode address stack controller.
package ustack_pkg;

    localparam int USTACK_AW = 11;
    localparam logic [USTACK_AW-1:0] USTACK_IRQ_VECTOR = 11'h7F0;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        RDATA,
        IPUSH,
        VEC,
        ERR
    } state_t;

endpackage

// File: rtl/ustack_depth_ctr.sv
// Saturating up/down entry counter for the microcode address stack.
module ustack_depth_ctr
    import ustack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          inc,
    input  logic          dec,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] count;

    // Simultaneous inc and dec cancel; each direction holds at its limit.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + DW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - DW'(1);
        end
    end

    assign depth = count;
    assign full  = (count == DW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ustack_sequencer.sv
// Call/return/interrupt sequencer driving the microcode address stack strobes.
// Build option: define USTACK_WRAP_EN to let a push while full overwrite the oldest entry.
module ustack_sequencer
    import ustack_pkg::*;
#(
    parameter int              DEPTH      = 8,
    parameter int              AW         = USTACK_AW,
    parameter logic [AW-1:0]   IRQ_VECTOR = AW'(USTACK_IRQ_VECTOR)
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         call_req,
    input  logic                         ret_req,
    input  logic                         irq_req,
    input  logic [AW-1:0]                pc,
    input  logic [AW-1:0]                operand,
    input  logic [AW-1:0]                stk_top,
    output logic                         ack,
    output logic                         stk_enable,
    output logic                         stk_select,
    output logic                         stk_pop,
    output logic                         stk_clear,
    output logic [AW-1:0]                next_pc,
    output logic                         next_pc_valid,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         busy
);

    state_t        state, state_nxt;
    logic [AW-1:0] target_q, target_nxt;
    logic          enable_nxt, pop_nxt, valid_nxt;
    logic          ovf_set, unf_set, inc, dec;
    logic          push_blocked;
    logic          unused_pc;

    // The PC reaches the stack data input directly through stk_select.
    assign unused_pc = ^pc;

`ifdef USTACK_WRAP_EN
    assign push_blocked = 1'b0;
`else
    assign push_blocked = full;
`endif

    ustack_depth_ctr #(
        .DEPTH (DEPTH)
    ) u_depth_ctr (
        .clk   (clk),
        .clear (clear),
        .inc   (inc),
        .dec   (dec),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        target_nxt = target_q;
        enable_nxt = 1'b0;
        pop_nxt    = 1'b0;
        valid_nxt  = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                // ack is decoded in the accept cycle so the redirect can follow one cycle later.
                if (!clear) begin
                    if (irq_req) begin
                        ack     = 1'b1;
                        ovf_set = full;
                        if (push_blocked) begin
                            state_nxt = ERR;
                        end else begin
                            state_nxt  = IPUSH;
                            enable_nxt = 1'b1;
                            inc        = 1'b1;
                        end
                    end else if (ret_req) begin
                        ack = 1'b1;
                        if (empty) begin
                            unf_set   = 1'b1;
                            state_nxt = ERR;
                        end else begin
                            state_nxt = POP;
                            pop_nxt   = 1'b1;
                            dec       = 1'b1;
                        end
                    end else if (call_req) begin
                        ack     = 1'b1;
                        ovf_set = full;
                        if (push_blocked) begin
                            state_nxt = ERR;
                        end else begin
                            state_nxt  = PUSH;
                            enable_nxt = 1'b1;
                            inc        = 1'b1;
                            valid_nxt  = 1'b1;
                            target_nxt = operand;
                        end
                    end
                end
            end
            PUSH: state_nxt = IDLE;
            IPUSH: begin
                state_nxt  = VEC;
                valid_nxt  = 1'b1;
                target_nxt = IRQ_VECTOR;
            end
            POP: begin
                state_nxt = RDATA;
                valid_nxt = 1'b1;
            end
            RDATA: begin
                state_nxt  = IDLE;
                target_nxt = stk_top;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= IDLE;
            target_q      <= '0;
            stk_enable    <= 1'b0;
            stk_select    <= 1'b0;
            stk_pop       <= 1'b0;
            next_pc_valid <= 1'b0;
            ovf_err       <= 1'b0;
            unf_err       <= 1'b0;
            stk_clear     <= 1'b1;
        end else begin
            state         <= state_nxt;
            target_q      <= target_nxt;
            stk_enable    <= enable_nxt;
            stk_select    <= enable_nxt;
            stk_pop       <= pop_nxt;
            next_pc_valid <= valid_nxt;
            ovf_err       <= ovf_err | ovf_set;
            unf_err       <= unf_err | unf_set;
            stk_clear     <= 1'b0;
        end
    end

    // The popped address is only valid during RDATA, so it bypasses the target register.
    assign next_pc = (state == RDATA) ? stk_top : target_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ustack_sequencer.sv
// Directed self-checking bench for ustack_sequencer (DEPTH=8).
module tb_ustack_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 11;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          clear;
    logic          call_req, ret_req, irq_req;
    logic [AW-1:0] pc, operand, stk_top;
    logic          ack, stk_enable, stk_select, stk_pop, stk_clear;
    logic [AW-1:0] next_pc;
    logic          next_pc_valid;
    logic [DW-1:0] depth;
    logic          full, empty, ovf_err, unf_err, busy;

    int n_cmp = 0;
    int n_err = 0;

    ustack_sequencer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .call_req      (call_req),
        .ret_req       (ret_req),
        .irq_req       (irq_req),
        .pc            (pc),
        .operand       (operand),
        .stk_top       (stk_top),
        .ack           (ack),
        .stk_enable    (stk_enable),
        .stk_select    (stk_select),
        .stk_pop       (stk_pop),
        .stk_clear     (stk_clear),
        .next_pc       (next_pc),
        .next_pc_valid (next_pc_valid),
        .depth         (depth),
        .full          (full),
        .empty         (empty),
        .ovf_err       (ovf_err),
        .unf_err       (unf_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
    endtask

    initial begin
        clear    = 1'b1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        irq_req  = 1'b0;
        pc       = 11'h010;
        operand  = 11'h123;
        stk_top  = 11'h000;

        // Reset state
        next_cycle();
        clear = 1'b0;
        #1;
        check("rst_stk_clear", stk_clear, 1);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf_err, 0);
        check("rst_unf", unf_err, 0);
        check("rst_busy", busy, 0);
        check("rst_enable", stk_enable, 0);
        check("rst_pop", stk_pop, 0);
        check("rst_valid", next_pc_valid, 0);
        check("rst_next_pc", next_pc, 0);
        check("rst_ack", ack, 0);
        next_cycle();
        check("clear_pulse_end", stk_clear, 0);

        // CALL: redirect one cycle after accept
        call_req = 1'b1;
        #1;
        check("call_ack", ack, 1);
        next_cycle();
        call_req = 1'b0;
        #1;
        check("call_enable", stk_enable, 1);
        check("call_select", stk_select, 1);
        check("call_valid", next_pc_valid, 1);
        check("call_next_pc", next_pc, 11'h123);
        check("call_depth", depth, 1);
        check("call_busy", busy, 1);
        next_cycle();
        check("call_idle_valid", next_pc_valid, 0);
        check("call_idle_enable", stk_enable, 0);
        check("call_idle_busy", busy, 0);

        // RET: pop then redirect to stack top
        ret_req = 1'b1;
        stk_top = 11'h010;
        #1;
        check("ret_ack", ack, 1);
        next_cycle();
        ret_req = 1'b0;
        #1;
        check("ret_pop", stk_pop, 1);
        check("ret_pop_no_enable", stk_enable, 0);
        check("ret_pop_valid", next_pc_valid, 0);
        check("ret_depth", depth, 0);
        check("ret_empty", empty, 1);
        next_cycle();
        check("ret_valid", next_pc_valid, 1);
        check("ret_next_pc", next_pc, 11'h010);
        check("ret_pop_end", stk_pop, 0);
        next_cycle();
        check("ret_idle_valid", next_pc_valid, 0);
        check("ret_idle_busy", busy, 0);

        // Priority: bring depth to 1, then irq/ret/call together
        operand  = 11'h200;
        call_req = 1'b1;
        next_cycle();
        call_req = 1'b0;
        next_cycle();
        check("prio_pre_depth", depth, 1);
        pc       = 11'h055;
        irq_req  = 1'b1;
        ret_req  = 1'b1;
        call_req = 1'b1;
        #1;
        check("prio_ack", ack, 1);
        next_cycle();
        irq_req = 1'b0;
        #1;
        check("irq_enable", stk_enable, 1);
        check("irq_select", stk_select, 1);
        check("irq_no_pop", stk_pop, 0);
        check("irq_push_valid", next_pc_valid, 0);
        check("irq_depth", depth, 2);
        check("irq_busy_no_ack", ack, 0);
        next_cycle();
        check("vec_valid", next_pc_valid, 1);
        check("vec_next_pc", next_pc, 11'h7F0);
        check("vec_enable", stk_enable, 0);
        next_cycle();
        stk_top = 11'h055;
        #1;
        check("prio_idle_busy", busy, 0);
        check("prio_ret_ack", ack, 1);
        next_cycle();
        ret_req  = 1'b0;
        call_req = 1'b0;
        #1;
        check("prio_ret_pop", stk_pop, 1);
        check("prio_ret_no_enable", stk_enable, 0);
        check("prio_ret_depth", depth, 1);
        next_cycle();
        check("prio_ret_valid", next_pc_valid, 1);
        check("prio_ret_next_pc", next_pc, 11'h055);
        next_cycle();
        check("prio_done_busy", busy, 0);

        // Underflow: ret at empty
        pulse_clear();
        #1;
        check("unf_pre_depth", depth, 0);
        ret_req = 1'b1;
        #1;
        check("unf_ack", ack, 1);
        next_cycle();
        check("unf_no_pop", stk_pop, 0);
        check("unf_flag", unf_err, 1);
        check("unf_busy", busy, 1);
        check("unf_no_valid", next_pc_valid, 0);
        call_req = 1'b1;
        next_cycle();
        check("err_ignore_ack", ack, 0);
        check("err_still_busy", busy, 1);
        check("err_no_enable", stk_enable, 0);
        check("err_depth", depth, 0);
        ret_req  = 1'b0;
        call_req = 1'b0;
        pulse_clear();
        #1;
        check("unf_cleared", unf_err, 0);
        check("unf_idle", busy, 0);
        check("unf_stk_clear", stk_clear, 1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            operand  = AW'(32'h100 + i);
            call_req = 1'b1;
            #1;
            check("fill_ack", ack, 1);
            next_cycle();
            call_req = 1'b0;
            #1;
            check("fill_depth", depth, i + 1);
            next_cycle();
        end
        check("fill_full", full, 1);
        check("fill_no_ovf", ovf_err, 0);
        operand  = 11'h3AB;
        call_req = 1'b1;
        #1;
        check("ovf_ack", ack, 1);
        next_cycle();
        call_req = 1'b0;
        #1;
        check("ovf_flag", ovf_err, 1);
        check("ovf_depth", depth, DEPTH);
`ifdef USTACK_WRAP_EN
        check("wrap_enable", stk_enable, 1);
        check("wrap_valid", next_pc_valid, 1);
        check("wrap_next_pc", next_pc, 11'h3AB);
        next_cycle();
        check("wrap_busy_drop", busy, 0);
        check("wrap_depth", depth, DEPTH);
`else
        check("ovf_no_enable", stk_enable, 0);
        check("ovf_no_valid", next_pc_valid, 0);
        check("ovf_busy", busy, 1);
        next_cycle();
        call_req = 1'b1;
        #1;
        check("ovf_err_ignore_ack", ack, 0);
        check("ovf_err_busy", busy, 1);
        call_req = 1'b0;
`endif
        pulse_clear();
        #1;
        check("ovf_cleared", ovf_err, 0);
        check("ovf_clear_full", full, 0);

        // Clear while the return redirect is pending
        operand  = 11'h044;
        call_req = 1'b1;
        next_cycle();
        call_req = 1'b0;
        next_cycle();
        ret_req = 1'b1;
        stk_top = 11'h077;
        next_cycle();
        ret_req = 1'b0;
        clear   = 1'b1;
        #1;
        check("abort_pop", stk_pop, 1);
        next_cycle();
        clear = 1'b0;
        #1;
        check("abort_no_valid", next_pc_valid, 0);
        check("abort_depth", depth, 0);
        check("abort_busy", busy, 0);
        check("abort_no_pop", stk_pop, 0);
        next_cycle();
        check("abort_still_no_valid", next_pc_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
